assoc_score_argmax: RTL and testbench
=====================================

# assoc_score_argmax

Sequential similarity accumulator and classifier for the associative memory: the consumer of the per-cycle ANDed chunks (query AND class HV, 26 classes a..z). Each accepted chunk is popcounted per class and added to a per-class score. After the final chunk, a sequential argmax scan runs over the 26 scores. It reports the winning class index and its score with a one-cycle valid pulse.

## Interface
Parameters:
- BITWIDTH, 5, bits per class chunk per cycle (500 at full width); must match the AND array.
- NUM_CHUNKS, 20, chunks per query HV; must be ≥ 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new query; honoured only in IDLE.
- in_valid  in  1  and_vec carries a valid chunk this cycle.
- and_vec  in  26*BITWIDTH  ANDed chunks; class k (a=0 … z=25) in bits [k*BITWIDTH +: BITWIDTH].
- busy  out  1  high whenever state ≠ IDLE.
- out_valid  out  1  one-cycle pulse; result is valid.
- out_class  out  5  winning class index, 0..25.
- out_score  out  SCORE_W  winning score; SCORE_W = $clog2(BITWIDTH*NUM_CHUNKS+1).

## Operation
- States: IDLE, ACCUM, SCAN, DONE.
- IDLE:
  - start=1 clears all 26 accumulators and chunk_cnt, then moves to ACCUM.
  - in_valid is ignored in IDLE, including in the same cycle as start.
- ACCUM:
  - Each cycle with in_valid=1: acc[k] += popcount(slice k), for all k in parallel; chunk_cnt increments.
  - Cycles with in_valid=0 are bubbles; nothing changes.
  - Accepting chunk NUM_CHUNKS-1 moves to SCAN with scan_idx=0.
- SCAN: one class per cycle.
  - At idx 0: best=acc[0], best_idx=0.
  - At idx>0: replace only if acc[idx] > best (strict). Ties therefore resolve to the lowest index.
  - After idx 25, move to DONE.
- DONE:
  - out_valid=1 for exactly one cycle, then move to IDLE.
  - out_class/out_score hold their values until the next result or reset.
- start outside IDLE is ignored. There is no abort; rst is the only way to cancel.
- Arithmetic:
  - Accumulators are SCORE_W wide and unsigned; they cannot overflow by construction.
  - Popcount width is $clog2(BITWIDTH+1), zero-extended before the add.

## Timing
- Reset values:
  - state=IDLE; busy=0, out_valid=0, out_class=0, out_score=0.
  - All accumulators, chunk_cnt and scan_idx are 0.
- busy rises the cycle after start is sampled in IDLE. It falls the cycle after DONE.
- Latency: edge E0 accepts the final chunk; SCAN processes idx 0..25 on edges E1..E26. out_valid is high during the cycle after E26.
- Throughput: one query per NUM_CHUNKS + (number of bubbles) + 28 cycles, counting start, SCAN and DONE.
- Reset mid-operation (any state): on the next edge everything returns to reset values. No partial result is emitted, and no accumulator residue carries into the next query.
- start asserted in the DONE cycle is ignored. start in the following IDLE cycle is accepted.

## Structure
- Package assoc_pkg holds:
  - NUM_CLASSES=26 and CLASS_IDX_W=5.
  - The state encoding (IDLE, ACCUM, SCAN, DONE).
  - The and_vec slice-index helper.
- Sub-module assoc_popcount (parameter BITWIDTH; in [BITWIDTH-1:0]; out [$clog2(BITWIDTH+1)-1:0]), purely combinational and instantiated 26× via generate.
- The FSM, accumulator bank and argmax scan live in the top module.

## Test plan
All scenarios use BITWIDTH=5 and NUM_CHUNKS=4.
1. start, then 4 chunks of and_vec=0 → out_valid pulse 26 cycles after the last chunk with out_class=0 and out_score=0. busy is low one cycle later.
2. Class 2 slice =5'b11111 and all other slices 0, for 4 chunks → out_class=2, out_score=20.
3. Classes 5 and 9 both 5'b10101 and all others 0, for 4 chunks → out_class=5, out_score=12 (tie goes to the lower index).
4. Class 25 slice =5'b00011 and class 24 slice =5'b00001, 4 chunks with in_valid bubbles between each → out_class=25, out_score=8. The bubbles add no counts.
5. rst pulsed after 2 accepted chunks → busy=0 and no out_valid. A fresh query of 4 chunks of class 0 =5'b00001 → out_class=0, out_score=4 (no residue from the cancelled query).
6. start pulsed while busy, and in_valid with nonzero and_vec while IDLE → both ignored. The result matches scenario 2 when run afterwards.

Source files
------------

// File: rtl/assoc_pkg.sv
// Shared definitions for the associative-memory scoring slice.
// Holds the class count and index width, the scorer FSM state type, and
// the helper that maps a class index to its and_vec bit offset.
package assoc_pkg;

    localparam int unsigned NUM_CLASSES = 26;
    localparam int unsigned CLASS_IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SCAN,
        DONE
    } state_t;

    // Class k owns and_vec[k*bw +: bw].
    function automatic int unsigned slice_lo(input int unsigned k, input int unsigned bw);
        return k * bw;
    endfunction

endpackage

// File: rtl/assoc_popcount.sv
// Combinational popcount of one class chunk.
// Ports:
//   in  [BITWIDTH-1:0]            chunk bits
//   out [$clog2(BITWIDTH+1)-1:0]  number of set bits in 'in'
module assoc_popcount #(
    parameter int BITWIDTH = 5
) (
    input  logic [BITWIDTH-1:0]             in,
    output logic [$clog2(BITWIDTH+1)-1:0]   out
);

    localparam int PC_W = $clog2(BITWIDTH + 1);

    always_comb begin
        out = '0;
        for (int unsigned i = 0; i < BITWIDTH; i++) begin
            out = out + PC_W'(in[i]);
        end
    end

endmodule

// File: rtl/assoc_score_argmax.sv
// Per-class similarity accumulator with sequential argmax.
// Each accepted chunk of and_vec is popcounted per class and added to that
// class's score. After NUM_CHUNKS chunks the 26 scores are scanned one per
// cycle; the winner (lowest index on ties) is reported with a one-cycle
// out_valid pulse.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      begin a query (only honoured in IDLE)
//   in_valid   and_vec holds a chunk this cycle (only used in ACCUM)
//   and_vec    26 class chunks, class k at [k*BITWIDTH +: BITWIDTH]
//   busy       high whenever the FSM is not IDLE
//   out_valid  one-cycle result strobe
//   out_class  winning class index, held until next result or reset
//   out_score  winning score, held until next result or reset
module assoc_score_argmax
    import assoc_pkg::*;
#(
    parameter int BITWIDTH   = 5,
    parameter int NUM_CHUNKS = 20
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic                                        in_valid,
    input  logic [NUM_CLASSES*BITWIDTH-1:0]             and_vec,
    output logic                                        busy,
    output logic                                        out_valid,
    output logic [CLASS_IDX_W-1:0]                      out_class,
    output logic [$clog2(BITWIDTH*NUM_CHUNKS+1)-1:0]    out_score
);

    localparam int SCORE_W = $clog2(BITWIDTH * NUM_CHUNKS + 1);
    localparam int PC_W    = $clog2(BITWIDTH + 1);
    localparam int CNT_W   = $clog2(NUM_CHUNKS + 1);

    localparam logic [CNT_W-1:0]       LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);
    localparam logic [CLASS_IDX_W-1:0] LAST_CLASS = CLASS_IDX_W'(NUM_CLASSES - 1);

    state_t                 state;
    logic [SCORE_W-1:0]     acc [NUM_CLASSES];
    logic [PC_W-1:0]        pc  [NUM_CLASSES];
    logic [CNT_W-1:0]       chunk_cnt;
    logic [CLASS_IDX_W-1:0] scan_idx;
    logic [SCORE_W-1:0]     best;
    logic [CLASS_IDX_W-1:0] best_idx;

    logic [SCORE_W-1:0]     cand;
    logic                   take;

    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_pc
        assoc_popcount #(.BITWIDTH(BITWIDTH)) u_pc (
            .in  (and_vec[slice_lo(k, BITWIDTH) +: BITWIDTH]),
            .out (pc[k])
        );
    end

    // Index 0 seeds the running best; later indices replace it only when
    // strictly greater, so ties keep the lowest index.
    always_comb begin
        cand = acc[scan_idx];
        take = (scan_idx == '0) || (cand > best);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_class <= '0;
            out_score <= '0;
            chunk_cnt <= '0;
            scan_idx  <= '0;
            best      <= '0;
            best_idx  <= '0;
            for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
                acc[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
                            acc[k] <= '0;
                        end
                        chunk_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
                            acc[k] <= acc[k] + SCORE_W'(pc[k]);
                        end
                        chunk_cnt <= chunk_cnt + 1'b1;
                        if (chunk_cnt == LAST_CHUNK) begin
                            scan_idx <= '0;
                            state    <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (take) begin
                        best     <= cand;
                        best_idx <= scan_idx;
                    end
                    // The last comparison is folded straight into the
                    // outputs so the result is presented in the DONE cycle.
                    if (scan_idx == LAST_CLASS) begin
                        out_valid <= 1'b1;
                        out_class <= take ? scan_idx : best_idx;
                        out_score <= take ? cand : best;
                        state     <= DONE;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                DONE: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_assoc_score_argmax.sv
module tb_assoc_score_argmax;

    localparam int BW   = 5;
    localparam int NC   = 4;
    localparam int NCLS = 26;
    localparam int VW   = NCLS * BW;
    localparam int SW   = $clog2(BW * NC + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [VW-1:0] and_vec;
    logic          busy;
    logic          out_valid;
    logic [4:0]    out_class;
    logic [SW-1:0] out_score;

    always #5 clk = ~clk;

    assoc_score_argmax #(.BITWIDTH(BW), .NUM_CHUNKS(NC)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .and_vec   (and_vec),
        .busy      (busy),
        .out_valid (out_valid),
        .out_class (out_class),
        .out_score (out_score)
    );

    int checks = 0;
    int errors = 0;

    logic [VW-1:0] chunk_q [NC];

    typedef struct {
        string         name;
        logic [VW-1:0] vec;
        int            bub;
        int            exp_cls;
        int            exp_sc;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] one_class(input int k, input logic [BW-1:0] v);
        logic [VW-1:0] r;
        r = '0;
        r[k*BW +: BW] = v;
        return r;
    endfunction

    // Random vector; some slices forced to all-ones to make ties frequent.
    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] r;
        for (int k = 0; k < NCLS; k++) begin
            if ($urandom_range(0, 3) == 0) r[k*BW +: BW] = '1;
            else                           r[k*BW +: BW] = BW'($urandom);
        end
        return r;
    endfunction

    // Reference: total set bits per class over all chunks, then first maximum.
    function automatic void model(output int cls, output int sc);
        int            s [NCLS];
        logic [VW-1:0] w;
        logic [BW-1:0] sl;
        foreach (s[k]) s[k] = 0;
        for (int c = 0; c < NC; c++) begin
            w = chunk_q[c];
            for (int k = 0; k < NCLS; k++) begin
                sl = w[k*BW +: BW];
                s[k] += $countones(sl);
            end
        end
        cls = 0;
        sc  = s[0];
        for (int k = 1; k < NCLS; k++) begin
            if (s[k] > sc) begin
                cls = k;
                sc  = s[k];
            end
        end
    endfunction

    // Runs one query from IDLE using chunk_q. 'noise' injects start pulses in
    // ACCUM, SCAN and DONE and a valid chunk in the start cycle, all of which
    // must be ignored.
    task automatic do_query(input string tag, input int bub, input bit noise,
                            input int exp_cls, input int exp_sc);
        int cyc;
        @(negedge clk);
        start = 1'b1;
        if (noise) begin
            in_valid = 1'b1;
            and_vec  = '1;
        end
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        chk({tag, "_busy_rise"}, busy, 1);
        if (noise) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int c = 0; c < NC; c++) begin
            for (int b = 0; b < bub; b++) begin
                in_valid = 1'b0;
                and_vec  = rnd_vec();
                @(negedge clk);
            end
            in_valid = 1'b1;
            and_vec  = chunk_q[c];
            @(negedge clk);
        end
        in_valid = 1'b0;
        and_vec  = rnd_vec();
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            start = (noise && cyc == 5);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, cyc, 26);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_class"}, out_class, exp_cls);
        chk({tag, "_score"}, out_score, exp_sc);
        chk({tag, "_busy_done"}, busy, 1);
        if (noise) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_pulse_end"}, out_valid, 0);
        chk({tag, "_busy_fall"}, busy, 0);
        @(negedge clk);
        chk({tag, "_class_hold"}, out_class, exp_cls);
        chk({tag, "_score_hold"}, out_score, exp_sc);
    endtask

    initial begin
        int ecls, esc, seen;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; and_vec = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_class", out_class, 0);
        chk("reset_score", out_score, 0);

        tbl[0] = '{"all_zero",  '0,                                     0, 0,  0};
        tbl[1] = '{"class2",    one_class(2, 5'b11111),                 0, 2,  20};
        tbl[2] = '{"tie_5_9",   one_class(5, 5'b10101) | one_class(9, 5'b10101), 0, 5, 12};
        tbl[3] = '{"bubbles",   one_class(25, 5'b00011) | one_class(24, 5'b00001), 2, 25, 8};

        for (int t = 0; t < 4; t++) begin
            for (int c = 0; c < NC; c++) chunk_q[c] = tbl[t].vec;
            do_query(tbl[t].name, tbl[t].bub, 1'b0, tbl[t].exp_cls, tbl[t].exp_sc);
        end

        // Reset after two accepted chunks cancels the query without output.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            and_vec  = '1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_class", out_class, 0);
        chk("rst_score", out_score, 0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid || busy) seen++;
            @(negedge clk);
        end
        chk("rst_no_output", seen, 0);
        for (int c = 0; c < NC; c++) chunk_q[c] = one_class(0, 5'b00001);
        do_query("after_rst", 0, 1'b0, 0, 4);

        // Valid chunks while IDLE are ignored; start is ignored while busy.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            and_vec  = '1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("idle_ignore_busy", busy, 0);
        for (int c = 0; c < NC; c++) chunk_q[c] = one_class(2, 5'b11111);
        do_query("noise", 0, 1'b1, 2, 20);

        // Randomized queries against the reference model.
        for (int q = 0; q < 12; q++) begin
            for (int c = 0; c < NC; c++) chunk_q[c] = rnd_vec();
            model(ecls, esc);
            do_query($sformatf("rand%0d", q), $urandom_range(0, 2), q[0], ecls, esc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
